// File: rtl/buf_rd_seq.sv
// buf_rd_seq: buffer-read responder between the controller and the weight/IF SRAMs.
// Converts w_read/if_read, clr_w/clr_if and switch into SRAM read strobes and
// addresses, reports tile completion and tracks the ping-pong weight bank.
// Optional build macro: OVERRUN_CHK_EN adds a sticky ovr_err output.

// One read path: tile counter, tile base and a one-cycle-latency read strobe.
module buf_rd_path #(
    parameter int LEN   = 4,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          clr,
    input  logic          first,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] addr
);

    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt;
    logic [AW-1:0] base;
    logic          accept;

    assign done   = (cnt == CW'(LEN));
    assign accept = rd & ~done & ~clr;

    // Count accepted reads, issue strobe/address one cycle later, advance base on clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            base  <= '0;
            rd_en <= 1'b0;
            addr  <= '0;
        end else begin
            rd_en <= accept;
            if (clr) begin
                cnt <= '0;
                // Explicit wrap keeps the base below DEPTH even when DEPTH is not a power of two.
                if (first) begin
                    base <= '0;
                end else if (done) begin
                    base <= (base == AW'(DEPTH - LEN)) ? '0 : base + AW'(LEN);
                end
            end else if (accept) begin
                cnt  <= cnt + CW'(1);
                addr <= base + AW'(cnt);
            end
        end
    end

endmodule

module buf_rd_seq #(
    parameter int W_LEN    = 4,
    parameter int IF_LEN   = 8,
    parameter int W_DEPTH  = 16,
    parameter int IF_DEPTH = 32,
    parameter int W_AW     = $clog2(W_DEPTH),
    parameter int IF_AW    = $clog2(IF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_read,
    input  logic             if_read,
    input  logic             clr_w,
    input  logic             clr_if,
    input  logic             switch,
    input  logic             first,
    output logic             w_done,
    output logic             if_done,
    output logic             w_rd_en,
    output logic [W_AW-1:0]  w_addr,
    output logic             if_rd_en,
    output logic [IF_AW-1:0] if_addr,
    output logic             w_bank
`ifdef OVERRUN_CHK_EN
    ,
    output logic             ovr_err
`endif
);

    buf_rd_path #(
        .LEN   (W_LEN),
        .DEPTH (W_DEPTH),
        .AW    (W_AW)
    ) u_w_path (
        .clk   (clk),
        .rst   (rst),
        .rd    (w_read),
        .clr   (clr_w),
        .first (first),
        .done  (w_done),
        .rd_en (w_rd_en),
        .addr  (w_addr)
    );

    buf_rd_path #(
        .LEN   (IF_LEN),
        .DEPTH (IF_DEPTH),
        .AW    (IF_AW)
    ) u_if_path (
        .clk   (clk),
        .rst   (rst),
        .rd    (if_read),
        .clr   (clr_if),
        .first (first),
        .done  (if_done),
        .rd_en (if_rd_en),
        .addr  (if_addr)
    );

    // Ping-pong weight bank: toggles once per switch pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_bank <= 1'b0;
        end else if (switch) begin
            w_bank <= ~w_bank;
        end
    end

`ifdef OVERRUN_CHK_EN
    // Sticky flag for reads requested after a tile has already completed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_err <= 1'b0;
        end else if ((w_read & w_done & ~clr_w) | (if_read & if_done & ~clr_if)) begin
            ovr_err <= 1'b1;
        end
    end
`endif

endmodule
